// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters that share one 8:1 mux.
// Optional owner lock that overrides the hold limit: define RR_ARBITER8_LOCK_EN.
//
// state  | meaning
// S_IDLE | no owner; grant=0, out_valid=0; the next owner is picked from req
// S_GRANT| switch owns the mux; out_valid=1 until the owner drops req or the hold limit is hit
module rr_arbiter8 #(
  parameter int N        = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   req,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  input  logic [N-1:0] in4,
  input  logic [N-1:0] in5,
  input  logic [N-1:0] in6,
  input  logic [N-1:0] in7,
`ifdef RR_ARBITER8_LOCK_EN
  input  logic         lock,
`endif
  output logic [7:0]   grant,
  output logic [2:0]   switch,
  output logic [N-1:0] out_data,
  output logic         out_valid
);

  // The counter only has to reach MAX_HOLD-1, so clog2(MAX_HOLD) bits are enough.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state;
  logic [7:0]    r_grant;
  logic [2:0]    r_switch;
  logic          r_valid;
  logic [HW-1:0] r_hold_cnt;
  logic [2:0]    r_last;

  logic [2:0]    w_cand;
  logic [2:0]    w_pick_idx;
  logic          w_pick_found;
  logic          w_owner_req;
  logic          w_at_limit;
  logic          w_lock_hold;
  logic          w_release;

  // Search last+1, last+2, ... (mod 8) for the first active request.
  always_comb begin
    w_cand       = 3'd0;
    w_pick_idx   = 3'd0;
    w_pick_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      w_cand = r_last + 3'(k);
      if (!w_pick_found && req[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand;
      end
    end
  end

  assign w_owner_req = req[r_switch];
  assign w_at_limit  = (r_hold_cnt == HOLD_LAST);

`ifdef RR_ARBITER8_LOCK_EN
  assign w_lock_hold = lock & w_owner_req;
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_release = !w_owner_req || (w_at_limit && !w_lock_hold);

  // Arbitration FSM with registered grant/switch/valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= 8'h00;
      r_switch   <= 3'd0;
      r_valid    <= 1'b0;
      r_hold_cnt <= '0;
      r_last     <= 3'd7;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_found) begin
            r_state    <= S_GRANT;
            r_grant    <= 8'h01 << w_pick_idx;
            r_switch   <= w_pick_idx;
            r_last     <= w_pick_idx;
            r_hold_cnt <= '0;
            r_valid    <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            // switch is left alone so out_data stays stable through the gap cycle
            r_state <= S_IDLE;
            r_grant <= 8'h00;
            r_valid <= 1'b0;
          end else if (!w_at_limit) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= 8'h00;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Shared 8:1 datapath mux steered by the registered owner index.
  always_comb begin
    case (r_switch)
      3'd0:    out_data = in0;
      3'd1:    out_data = in1;
      3'd2:    out_data = in2;
      3'd3:    out_data = in3;
      3'd4:    out_data = in4;
      3'd5:    out_data = in5;
      3'd6:    out_data = in6;
      default: out_data = in7;
    endcase
  end

  assign grant     = r_grant;
  assign switch    = r_switch;
  assign out_valid = r_valid;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8:1 N-bit mux datapath among 8 requesters.
- Registers the owner index, drives the mux select internally, and presents the owner's data with a valid flag.
- Bounds each tenure with a hold-limit counter and inserts one idle cycle between owners, so the select never changes while `out_valid` is high.
- Sits between client blocks and a shared downstream resource (bus, display port, ALU operand).

Parameters:
- N, 1, data width of each requester's input and of `out_data`.
- MAX_HOLD, 16, maximum consecutive GRANT cycles per tenure; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- in0..in7  input  N each  requester data inputs.
- grant  output  8  one-hot grant, registered; all zero when no owner.
- switch  output  3  registered owner index; also drives the internal 8:1 mux select.
- out_data  output  N  owner data, combinational through the 8:1 mux from registered `switch`.
- out_valid  output  1  high only in GRANT.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, grant=8'h00, switch=3'd0, out_valid=0, hold_cnt=0, last=3'd7.
  - `last` = 7 makes requester 0 the first priority.
- State machine has two states: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit searching last+1, last+2, … modulo 8 (wraps 7->0).
  - Next edge: state=GRANT, grant=onehot(idx), switch=idx, last=idx, hold_cnt=0, out_valid=1.
- GRANT:
  - Each cycle, hold_cnt increments by 1, saturating; its width is sized for MAX_HOLD.
  - Release when req[switch]==0, or hold_cnt==MAX_HOLD-1 (checked on the current cycle).
  - On release, next edge: state=IDLE, grant=0, out_valid=0. `switch` holds its value, so `out_data` stays stable but is not valid.
  - With no release, all outputs hold.
- Latency:
  - req rising before edge k gives grant/out_valid high after edge k, from IDLE.
  - Every tenure is followed by exactly one IDLE cycle before the next grant.
  - A single requester holding req continuously gets MAX_HOLD valid cycles, 1 idle cycle, then is re-granted. Round-robin wraps back to it.
- Fairness: the requester just served has lowest priority at the next arbitration.
- Simultaneous events:
  - A new req arriving in the same cycle the owner drops is considered at the following IDLE cycle.
  - Requests from non-owners never preempt during GRANT.
- MAX_HOLD=1: every tenure is exactly one cycle, with a 1-cycle gap.
- Reset mid-tenure: outputs clear immediately (async); priority restarts at requester 0.
- `grant` is always one-hot or zero. `switch` is never X after reset.

Optional Feature:
- Macro: RR_ARBITER8_LOCK_EN.
- When defined:
  - Adds port `lock`, input, 1 bit.
  - In GRANT, while lock==1 and req[switch]==1, the hold-limit release is suppressed and hold_cnt stops at MAX_HOLD-1. The owner keeps the resource until it drops req or lock.
  - Dropping lock with hold_cnt already at MAX_HOLD-1 releases on that cycle.
- When undefined:
  - No `lock` port.
  - The hold limit always applies.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> grant=0, switch=0, out_valid=0 throughout; deassert rst mid-cycle to confirm async behaviour.
- req=8'h01 held, MAX_HOLD=4, in0=1 -> out_valid high 4 cycles, low 1, high 4 again; out_data=1 whenever valid.
- req=8'hFF held, MAX_HOLD=2, in_i=i -> switch sequence 0,1,…,7,0 each for 2 valid cycles with 1-cycle gaps; out_data matches switch when valid.
- last=5, req=8'h21 (bits 0,5) -> grant=8'h01 first, then 8'h20: wrap-around priority.
- Owner 3 drops req after 2 cycles, MAX_HOLD=16 -> out_valid falls next edge, 1 IDLE cycle, next requester granted; assert rst during GRANT -> grant=0 immediately, next grant starts from requester 0.
- With RR_ARBITER8_LOCK_EN defined, lock=1, req=8'h06, MAX_HOLD=2 -> requester 1 held 10 cycles; lock=0 -> release next edge, requester 2 granted after 1 gap cycle.
